// File: rtl/inv_sub_layer_serial_if.sv
// Valid/ready word handshake into and out of the nibble-serial inverse substitution layer.
interface inv_sub_layer_serial_if #(
    parameter int unsigned WIDTH = 48
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/inv_sub_layer_serial.sv
// Nibble-serial inverse substitution layer: one shared 4-bit unit walks the word LSB nibble first.
module inv_sub_nibble (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);
    // 15-n over four bits is exactly the bitwise complement
    assign nib_o = ~nib_i;
endmodule

module inv_sub_layer_serial #(
    parameter int unsigned WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    output logic                  busy,
    inv_sub_layer_serial_if.slave io
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = $clog2(NIB);

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;
    logic [3:0]       nib_in, nib_out;

    inv_sub_nibble u_sub (
        .nib_i (nib_in),
        .nib_o (nib_out)
    );

    always_comb begin
        nib_in = '0;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (cnt_q == CW'(i)) nib_in = work_q[i*4 +: 4];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        in_ready_d  = in_ready_q;
        if (clear) begin
            // abort leaves the working register untouched
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            in_ready_d  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (io.in_valid) begin
                        work_d     = io.in_data;
                        cnt_d      = '0;
                        state_d    = SUB;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end
                end
                SUB: begin
                    for (int unsigned i = 0; i < NIB; i++) begin
                        if (cnt_q == CW'(i)) work_d[i*4 +: 4] = nib_out;
                    end
                    if (cnt_q == CW'(NIB - 1)) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        in_ready_d  = 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = work_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_inv_sub_layer_serial.sv
// Directed bench for inv_sub_layer_serial with an expected-word queue, 48- and 16-bit instances.
module tb_inv_sub_layer_serial;
    logic clk = 1'b0;
    logic rst;
    logic clear_a, clear_b;
    logic busy_a, busy_b;
    int   total = 0;
    int   bad   = 0;
    int   n;
    logic [47:0] sb[$];

    inv_sub_layer_serial_if #(.WIDTH(48)) a ();
    inv_sub_layer_serial_if #(.WIDTH(16)) b ();

    inv_sub_layer_serial #(.WIDTH(48)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_a),
        .busy  (busy_a),
        .io    (a)
    );

    inv_sub_layer_serial #(.WIDTH(16)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_b),
        .busy  (busy_b),
        .io    (b)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] model_sub(input logic [47:0] d);
        logic [47:0] r;
        for (int i = 0; i < 12; i++) r[i*4 +: 4] = 4'd15 - d[i*4 +: 4];
        return r;
    endfunction

    function automatic logic [47:0] pop_exp();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send48(input logic [47:0] d);
        int k = 0;
        while (a.in_ready !== 1'b1 && k < 60) begin tick(); k++; end
        a.in_valid = 1'b1;
        a.in_data  = d;
        tick();
        a.in_valid = 1'b0;
        sb.push_back(model_sub(d));
    endtask

    task automatic wait_out48(output int cnt);
        cnt = 0;
        while (a.out_valid !== 1'b1 && cnt < 60) begin tick(); cnt++; end
    endtask

    initial begin
        rst = 1'b1;
        clear_a = 1'b0; clear_b = 1'b0;
        a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b1;
        b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 48'(a.out_valid), 48'd0);
        chk("rst_busy", 48'(busy_a), 48'd0);
        chk("rst_in_ready", 48'(a.in_ready), 48'd1);
        chk("rst_out_data", a.out_data, 48'd0);
        chk("rst_b_in_ready", 48'(b.in_ready), 48'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // basic word, downstream always ready
        send48(48'h0123456789AB);
        chk("t1_busy", 48'(busy_a), 48'd1);
        wait_out48(n);
        chk("t1_latency", 48'(n), 48'd12);
        chk("t1_data_const", a.out_data, 48'hFEDCBA987654);
        chk("t1_data_sb", a.out_data, pop_exp());
        tick();
        chk("t1_valid_drop", 48'(a.out_valid), 48'd0);
        chk("t1_in_ready", 48'(a.in_ready), 48'd1);

        // backpressure
        a.out_ready = 1'b0;
        send48(48'h0123456789AB);
        wait_out48(n);
        chk("bp_latency", 48'(n), 48'd12);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid_hold", 48'(a.out_valid), 48'd1);
            chk("bp_data_hold", a.out_data, 48'hFEDCBA987654);
            chk("bp_in_ready", 48'(a.in_ready), 48'd0);
        end
        chk("bp_data_sb", a.out_data, pop_exp());
        a.out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 48'(a.out_valid), 48'd0);
        chk("bp_release_ready", 48'(a.in_ready), 48'd1);

        // in_valid during SUB/DONE is ignored
        send48(48'h000000000000);
        tick(); tick(); tick();
        a.in_valid = 1'b1;
        a.in_data  = 48'hFFFFFFFFFFFF;
        chk("bi_in_ready_sub", 48'(a.in_ready), 48'd0);
        wait_out48(n);
        chk("bi_latency", 48'(n + 3), 48'd12);
        chk("bi_data", a.out_data, 48'hFFFFFFFFFFFF);
        chk("bi_data_sb", a.out_data, pop_exp());
        tick();
        chk("bi_not_taken_ready", 48'(a.in_ready), 48'd1);
        chk("bi_not_taken_busy", 48'(busy_a), 48'd0);
        tick();
        a.in_valid = 1'b0;
        sb.push_back(model_sub(48'hFFFFFFFFFFFF));
        chk("bi_accept_busy", 48'(busy_a), 48'd1);
        chk("bi_accept_ready", 48'(a.in_ready), 48'd0);
        wait_out48(n);
        chk("bi2_latency", 48'(n), 48'd12);
        chk("bi2_data", a.out_data, pop_exp());
        tick();

        // clear at counter 5
        send48(48'h123456789ABC);
        repeat (5) tick();
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        sb.delete();
        chk("clr_in_ready", 48'(a.in_ready), 48'd1);
        chk("clr_out_valid", 48'(a.out_valid), 48'd0);
        chk("clr_busy", 48'(busy_a), 48'd0);
        clear_a = 1'b1;
        a.in_valid = 1'b1;
        a.in_data  = 48'hAAAAAAAAAAAA;
        tick();
        clear_a = 1'b0;
        a.in_valid = 1'b0;
        chk("clr_prio_ready", 48'(a.in_ready), 48'd1);
        chk("clr_prio_busy", 48'(busy_a), 48'd0);
        send48(48'hAAAAAAAAAAAA);
        wait_out48(n);
        chk("clr_fresh_latency", 48'(n), 48'd12);
        chk("clr_fresh_data", a.out_data, 48'h555555555555);
        chk("clr_fresh_sb", a.out_data, pop_exp());
        tick();

        // async reset between edges mid-SUB
        send48(48'h13579BDF2468);
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 48'(a.out_valid), 48'd0);
        chk("ar_busy", 48'(busy_a), 48'd0);
        chk("ar_in_ready", 48'(a.in_ready), 48'd1);
        chk("ar_out_data", a.out_data, 48'd0);
        #1;
        rst = 1'b0;
        sb.delete();
        tick();
        send48(48'h0F0F0F0F0F0F);
        wait_out48(n);
        chk("ar_resume_latency", 48'(n), 48'd12);
        chk("ar_resume_data", a.out_data, 48'hF0F0F0F0F0F0);
        chk("ar_resume_sb", a.out_data, pop_exp());
        tick();

        // 16-bit instance
        b.in_valid = 1'b1;
        b.in_data  = 16'h3C0F;
        tick();
        b.in_valid = 1'b0;
        n = 0;
        while (b.out_valid !== 1'b1 && n < 60) begin tick(); n++; end
        chk("w16_latency", 48'(n), 48'd4);
        chk("w16_data", 48'(b.out_data), 48'h00000000C3F0);
        tick();
        chk("w16_done_ready", 48'(b.in_ready), 48'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
